// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped timer peripheral: register offsets,
// TCON bit positions and the decoded window size.
package timer_pkg;

    localparam int unsigned WIN_BYTES = 32;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_PRESC   = 5'h0C;
    localparam logic [4:0] OFF_SYSTICK = 5'h10;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    localparam int unsigned PRESC_W = 16;

endpackage

// File: rtl/timer_periph_if.sv
// Data-memory bus slice seen by the timer: EX-stage request, MEM-stage response
// and the level interrupt toward IF.
interface timer_periph_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    modport master (
        output addr, wdata, mem_read, mem_write,
        input  rdata, hit, irq
    );

    modport slave (
        input  addr, wdata, mem_read, mem_write,
        output rdata, hit, irq
    );

endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for the timer: counts 0..presc while enabled and fires one tick
// on the terminal count. Used only when TIMER_PRESCALE_EN is defined.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] div;

    // >= rather than == so lowering presc below the running count cannot
    // strand the divider on a 64K-cycle wrap.
    assign tick = en & (div >= presc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (clear) begin
            div <= '0;
        end else if (en) begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/timer_periph.sv
// Timer peripheral on the MIPS data-memory bus: TH/TL reload timer, TCON,
// free-running SYSTICK. Optional prescaler via TIMER_PRESCALE_EN.
module timer_periph
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h4000_0000,
    parameter logic [31:0] RESET_TH = 32'hFFFF_F000
)
(
    input  logic           clk,
    input  logic           reset,
    timer_periph_if.slave  bus
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic [31:0] rdata_q;
    logic        hit_q;

    logic [31:0] off;
    logic [4:0]  reg_off;
    logic        decoded;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick, count, ovf;
    logic [31:0] rd_val;
    logic        unused_addr_lsb;

    // Subtracting the base keeps decode correct for any word-aligned BASE.
    assign off             = bus.addr - BASE;
    assign decoded         = (off < WIN_BYTES);
    assign reg_off         = {off[4:2], 2'b00};
    assign unused_addr_lsb = &{1'b0, off[1:0]};

    assign wr_th   = bus.mem_write & decoded & (reg_off == OFF_TH);
    assign wr_tl   = bus.mem_write & decoded & (reg_off == OFF_TL);
    assign wr_tcon = bus.mem_write & decoded & (reg_off == OFF_TCON);

`ifdef TIMER_PRESCALE_EN
    logic               wr_presc;
    logic [PRESC_W-1:0] presc;

    assign wr_presc = bus.mem_write & decoded & (reg_off == OFF_PRESC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         presc <= '0;
        else if (wr_presc) presc <= bus.wdata[PRESC_W-1:0];
    end

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (tcon[TCON_EN]),
        .clear (wr_tcon),
        .presc (presc),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign count = tcon[TCON_EN] & tick;
    assign ovf   = count & (tl == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th      <= RESET_TH;
            tl      <= '0;
            tcon    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 1'b1;
            if (wr_th) th <= bus.wdata;
            // Reload reads the pre-edge th, so a same-cycle TH write lands after.
            if (wr_tl)      tl <= bus.wdata;
            else if (ovf)   tl <= th;
            else if (count) tl <= tl + 1'b1;
            if (wr_tcon)                    tcon <= bus.wdata[2:0];
            else if (ovf && tcon[TCON_IE])  tcon[TCON_IS] <= 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OFF_TH:      rd_val = th;
            OFF_TL:      rd_val = tl;
            OFF_TCON:    rd_val = {29'b0, tcon};
`ifdef TIMER_PRESCALE_EN
            OFF_PRESC:   rd_val = {{(32-PRESC_W){1'b0}}, presc};
`endif
            OFF_SYSTICK: rd_val = systick;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            rdata_q <= (bus.mem_read & decoded) ? rd_val : '0;
            hit_q   <= (bus.mem_read | bus.mem_write) & decoded;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.hit   = hit_q;
    assign bus.irq   = tcon[TCON_IS];

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: register access, reload/interrupt,
// same-cycle write precedence, decode boundaries, async reset, prescaler.
module tb_timer_periph;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_PRE  = BASE + 32'h0C;
    localparam logic [31:0] A_SYS  = BASE + 32'h10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    timer_periph_if bus();

    timer_periph #(
        .BASE     (32'h4000_0000),
        .RESET_TH (32'hFFFF_F000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_read  = r;
        bus.mem_write = w;
        step();
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(a, d, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        access(a, 32'h0, 1'b1, 1'b0);
        check(tag, bus.rdata, exp);
        check({tag, "_hit"}, {31'b0, bus.hit}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.addr  = '0;
        bus.wdata = '0;
        idle();
        step();
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_hit", {31'b0, bus.hit}, 32'd0);
        check("rst_irq", {31'b0, bus.irq}, 32'd0);
        reset = 1'b0;

        // SYSTICK counts one per edge since reset release
        repeat (10) step();
        rd(A_SYS, 32'd10, "systick_10");
        rd(A_SYS, 32'd11, "systick_11");
        rd(A_TCON, 32'h0, "tcon_reset");
        rd(A_TH, 32'hFFFF_F000, "th_reset");

        // overflow with interrupt enabled
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h3);
        check("irq_pre", {31'b0, bus.irq}, 32'd0);
        rd(A_TL, 32'hFFFF_FFFD, "tl_fd");
        rd(A_TL, 32'hFFFF_FFFE, "tl_fe");
        check("irq_before_ovf", {31'b0, bus.irq}, 32'd0);
        rd(A_TL, 32'hFFFF_FFFF, "tl_ff");
        check("irq_after_ovf", {31'b0, bus.irq}, 32'd1);
        rd(A_TL, 32'hFFFF_FFF0, "tl_reload");
        rd(A_TCON, 32'h7, "tcon_is_set");

        // TCON write in the same cycle as a second overflow wins
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h3);
        check("irq_cleared", {31'b0, bus.irq}, 32'd0);
        rd(A_TCON, 32'h3, "tcon_write_wins");
        rd(A_TL, 32'hFFFF_FFF1, "tl_after_ovf2");

        // TL write in the overflow cycle overrides the reload
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TL, 32'h10);
        rd(A_TL, 32'h10, "tl_write_wins");

        // outside the window: no hit, no register change
        access(BASE + 32'h20, 32'h1234, 1'b0, 1'b1);
        check("hit_above", {31'b0, bus.hit}, 32'd0);
        access(BASE - 32'h4, 32'h5678, 1'b0, 1'b1);
        check("hit_below", {31'b0, bus.hit}, 32'd0);
        access(BASE + 32'h20, 32'h0, 1'b1, 1'b0);
        check("rd_above_hit", {31'b0, bus.hit}, 32'd0);
        check("rd_above_data", bus.rdata, 32'h0);
        rd(A_TH, 32'hFFFF_FFF0, "th_untouched");

        // overflow with IE=0: reload but no interrupt
        wr(A_TCON, 32'h1);
        wr(A_TL, 32'hFFFF_FFFE);
        step();
        step();
        check("irq_ie0", {31'b0, bus.irq}, 32'd0);
        rd(A_TL, 32'hFFFF_FFF0, "tl_reload_ie0");
        rd(A_TCON, 32'h1, "tcon_ie0");

        // TH write during reload: TL takes old TH
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TH, 32'h100);
        rd(A_TL, 32'hFFFF_FFF0, "tl_old_th");
        rd(A_TH, 32'h100, "th_new");

        // reserved offsets
        wr(BASE + 32'h14, 32'hDEAD_BEEF);
        rd(BASE + 32'h14, 32'h0, "rsv_14");
        rd(BASE + 32'h1C, 32'h0, "rsv_1c");
`ifndef TIMER_PRESCALE_EN
        wr(A_PRE, 32'h3);
        rd(A_PRE, 32'h0, "presc_absent");
`endif

        // disabled counter holds; read+write returns pre-write value
        wr(A_TCON, 32'h0);
        wr(A_TL, 32'h5);
        step();
        access(A_TL, 32'h7, 1'b1, 1'b1);
        check("rw_old", bus.rdata, 32'h5);
        rd(A_TL + 32'h3, 32'h7, "rw_new_lsb_ignored");

        // asynchronous reset with a pending interrupt
        wr(A_TCON, 32'h3);
        wr(A_TL, 32'hFFFF_FFFF);
        step();
        check("irq_pending", {31'b0, bus.irq}, 32'd1);
        rd(A_TCON, 32'h7, "tcon_pending");
        reset = 1'b1;
        #2;
        check("async_irq", {31'b0, bus.irq}, 32'd0);
        check("async_hit", {31'b0, bus.hit}, 32'd0);
        check("async_rdata", bus.rdata, 32'h0);
        step();
        reset = 1'b0;
        rd(A_TCON, 32'h0, "tcon_after_rst");
        rd(A_TH, 32'hFFFF_F000, "th_after_rst");
        rd(A_TL, 32'h0, "tl_after_rst");

`ifdef TIMER_PRESCALE_EN
        wr(A_PRE, 32'hFFFF_0003);
        rd(A_PRE, 32'h3, "presc_rd");
        wr(A_TL, 32'h0);
        wr(A_TCON, 32'h1);
        step();
        step();
        step();
        rd(A_TL, 32'h0, "presc3_t4");
        step();
        step();
        step();
        rd(A_TL, 32'h1, "presc3_t8");
        wr(A_PRE, 32'h0);
        wr(A_TCON, 32'h1);
        wr(A_TL, 32'h100);
        rd(A_TL, 32'h100, "presc0_a");
        rd(A_TL, 32'h101, "presc0_b");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
